// File: rtl/pldata_pkg.sv
// Shared state encoding and RAM geometry constants for the PL data packer.
package pldata_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_LAST,
        S_DONE
    } state_t;

    localparam int RAM_WORD_BYTES = 4;
    localparam int PIXELS_MAX_DEF = 256;

endpackage

// File: rtl/pix_pair_reg.sv
// Pairs consecutive pixel samples into one RAM word and issues a one-cycle write strobe.
module pix_pair_reg
    import pldata_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          accept,
    input  logic                          odd,
    input  logic                          last,
    input  logic [DATA_W-1:0]             sample,
    output logic                          wr,
    output logic [RAM_WORD_BYTES*8-1:0]   data
);

    localparam int WORD_W = RAM_WORD_BYTES * 8;

    logic [DATA_W-1:0] low_half;

    // An even sample is parked; the odd partner (or the frame end) completes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_half <= '0;
            wr       <= 1'b0;
            data     <= '0;
        end else begin
            wr <= 1'b0;
            if (accept) begin
                if (!odd) begin
                    low_half <= sample;
                    if (last) begin
                        wr   <= 1'b1;
                        data <= {{(WORD_W-DATA_W){1'b0}}, sample};
                    end
                end else begin
                    wr   <= 1'b1;
                    data <= {sample, low_half};
                end
            end
        end
    end

endmodule

// File: rtl/pldata_packer.sv
// Packs one line of 16-bit pixel samples into 32-bit words for the PL data BRAM,
// alternating banks per completed frame so the PS can read the previous one.
module pldata_packer
    import pldata_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int PIXELS_MAX = PIXELS_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_in,
    input  logic [8:0]        pixel_num_in,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid_in,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    output logic              bank_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              err_o
);

    localparam int         BYTE_SHIFT = $clog2(RAM_WORD_BYTES);
    localparam int         WIDX_W     = ADDR_W - 1 - BYTE_SHIFT;
    localparam logic [8:0] PIX_LIMIT  = 9'(PIXELS_MAX);

    state_t              state;
    logic [8:0]          cnt_max;
    logic [8:0]          pix_cnt;
    logic [WIDX_W-1:0]   word_idx;
    logic [8:0]          start_len;
    logic                sample_accept;
    logic                sample_last;

    assign start_len     = (pixel_num_in > PIX_LIMIT) ? PIX_LIMIT : pixel_num_in;
    assign sample_accept = (state == S_CAPTURE) && sample_valid_in && !frame_start_in;
    assign sample_last   = (pix_cnt == cnt_max - 9'd1);

    // A start pulse wins over everything: from IDLE it begins a frame, elsewhere it aborts and restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt_max      <= '0;
            pix_cnt      <= '0;
            word_idx     <= '0;
            ram_addr_o   <= '0;
            bank_o       <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (frame_start_in) begin
                cnt_max  <= start_len;
                pix_cnt  <= '0;
                word_idx <= '0;
                busy_o   <= 1'b1;
                err_o    <= (state != S_IDLE);
                if (start_len == 9'd0) begin
                    state        <= S_DONE;
                    frame_done_o <= 1'b1;
                end else begin
                    state <= S_CAPTURE;
                end
            end else begin
                case (state)
                    S_CAPTURE: begin
                        if (sample_accept) begin
                            pix_cnt <= pix_cnt + 9'd1;
                            if (pix_cnt[0] || sample_last) begin
                                ram_addr_o <= {bank_o, word_idx, {BYTE_SHIFT{1'b0}}};
                                word_idx   <= word_idx + WIDX_W'(1);
                            end
                            if (sample_last) begin
                                state <= S_LAST;
                            end
                        end
                    end
                    S_LAST: begin
                        state        <= S_DONE;
                        frame_done_o <= 1'b1;
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        bank_o <= ~bank_o;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    pix_pair_reg #(
        .DATA_W (DATA_W)
    ) u_pix_pair_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (sample_accept),
        .odd    (pix_cnt[0]),
        .last   (sample_last),
        .sample (sample_in),
        .wr     (ram_wr_o),
        .data   (ram_data_o)
    );

endmodule

// File: tb/tb_pldata_packer.sv
// Directed self-checking bench for pldata_packer with hand-computed expectations.
module tb_pldata_packer;

    logic        clk;
    logic        rst_n;
    logic        frame_start_in;
    logic [8:0]  pixel_num_in;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic        ram_wr_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic        bank_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        err_o;

    int tests_run;
    int tests_failed;
    int done_cnt;
    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    pldata_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start_in  (frame_start_in),
        .pixel_num_in    (pixel_num_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .ram_wr_o        (ram_wr_o),
        .ram_addr_o      (ram_addr_o),
        .ram_data_o      (ram_data_o),
        .bank_o          (bank_o),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    // Log every RAM write and frame-done pulse mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wr_o) begin
                wr_addr_q.push_back(ram_addr_o);
                wr_data_q.push_back(ram_data_o);
            end
            if (frame_done_o) done_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [8:0] num, input logic valid, input logic [15:0] smp);
        frame_start_in  = start;
        pixel_num_in    = num;
        sample_valid_in = valid;
        sample_in       = smp;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 9'd0, 1'b0, 16'h0);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        frame_start_in = 1'b0;
        pixel_num_in = '0;
        sample_in = '0;
        sample_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state",
            {ram_wr_o, ram_addr_o, ram_data_o, bank_o, busy_o, frame_done_o, err_o}, 64'h0);
        rst_n = 1'b1;
        idleCycles(2);

        // Even-length frame, cycle exact
        clearLog();
        applyStimulus(1'b1, 9'd4, 1'b0, 16'h0);
        checkOutput("t1_start", {busy_o, ram_wr_o, frame_done_o}, 3'b100);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0001);
        checkOutput("t1_nowr0", ram_wr_o, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0002);
        checkOutput("t1_wr0", {ram_wr_o, ram_addr_o, ram_data_o}, {1'b1, 10'h000, 32'h00020001});
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0003);
        checkOutput("t1_nowr1", ram_wr_o, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0004);
        checkOutput("t1_wr1", {ram_wr_o, ram_addr_o, ram_data_o}, {1'b1, 10'h004, 32'h00040003});
        applyStimulus(1'b0, 9'd0, 1'b0, 16'h0);
        checkOutput("t1_done", {frame_done_o, ram_wr_o, busy_o, bank_o}, 4'b1010);
        applyStimulus(1'b0, 9'd0, 1'b0, 16'h0);
        checkOutput("t1_after", {frame_done_o, busy_o, bank_o}, 3'b001);
        checkOutput("t1_nwrites", wr_addr_q.size(), 2);

        // Odd length with gaps, now in bank 1
        clearLog();
        applyStimulus(1'b1, 9'd3, 1'b0, 16'h0);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'hAAAA);
        applyStimulus(1'b0, 9'd0, 1'b0, 16'h0);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'hBBBB);
        idleCycles(2);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'hCCCC);
        idleCycles(4);
        checkOutput("t2_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            checkOutput("t2_w0", {wr_addr_q[0], wr_data_q[0]}, {10'h200, 32'hBBBBAAAA});
            checkOutput("t2_w1", {wr_addr_q[1], wr_data_q[1]}, {10'h204, 32'h0000CCCC});
        end
        checkOutput("t2_done", done_cnt, 1);
        checkOutput("t2_bank", bank_o, 1'b0);

        // Ping-pong: clamped 300-pixel frame then a 256-pixel frame
        clearLog();
        applyStimulus(1'b1, 9'd300, 1'b0, 16'h0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 9'd0, 1'b1, 16'(i));
        idleCycles(3);
        applyStimulus(1'b1, 9'd256, 1'b0, 16'h0);
        for (int i = 0; i < 256; i++) applyStimulus(1'b0, 9'd0, 1'b1, 16'h1000 + 16'(i));
        idleCycles(4);
        checkOutput("t3_nwrites", wr_addr_q.size(), 256);
        checkOutput("t3_done", done_cnt, 2);
        checkOutput("t3_bank", bank_o, 1'b0);
        if (wr_addr_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                logic [15:0] base;
                int j;
                base = (i < 128) ? 16'h0000 : 16'h1000;
                j = (i < 128) ? i : i - 128;
                checkOutput("t3_addr", wr_addr_q[i], 64'(i * 4));
                checkOutput("t3_data", wr_data_q[i], {base + 16'(2*j+1), base + 16'(2*j)});
            end
        end

        // Restart while busy
        clearLog();
        applyStimulus(1'b1, 9'd8, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 9'd0, 1'b1, 16'h0011 + 16'(i));
        applyStimulus(1'b1, 9'd2, 1'b1, 16'h0099);
        checkOutput("t4_err", {err_o, busy_o, frame_done_o}, 3'b110);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0021);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0022);
        idleCycles(3);
        checkOutput("t4_nwrites", wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            checkOutput("t4_w0", {wr_addr_q[0], wr_data_q[0]}, {10'h000, 32'h00120011});
            checkOutput("t4_w1", {wr_addr_q[1], wr_data_q[1]}, {10'h004, 32'h00140013});
            checkOutput("t4_w2", {wr_addr_q[2], wr_data_q[2]}, {10'h000, 32'h00220021});
        end
        checkOutput("t4_done", done_cnt, 1);
        checkOutput("t4_sticky", {err_o, bank_o}, 2'b11);

        // Idle samples and zero-length frame
        clearLog();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 9'd0, 1'b1, 16'h5A5A);
        checkOutput("t5_idle_nowr", wr_addr_q.size(), 0);
        applyStimulus(1'b1, 9'd0, 1'b0, 16'h0);
        checkOutput("t5_zero_done", {err_o, frame_done_o, busy_o, ram_wr_o}, 4'b0110);
        applyStimulus(1'b0, 9'd0, 1'b0, 16'h0);
        checkOutput("t5_zero_after", {frame_done_o, busy_o, bank_o}, 3'b000);
        checkOutput("t5_nwrites", wr_addr_q.size(), 0);
        checkOutput("t5_ndone", done_cnt, 1);
        applyStimulus(1'b1, 9'd0, 1'b0, 16'h0);
        idleCycles(1);
        checkOutput("t5_bank1", bank_o, 1'b1);

        // Reset mid-frame
        applyStimulus(1'b1, 9'd4, 1'b0, 16'h0);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0005);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0006);
        checkOutput("t6_prewr", {ram_wr_o, ram_addr_o, busy_o}, {1'b1, 10'h200, 1'b1});
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_rst",
            {ram_wr_o, ram_addr_o, ram_data_o, bank_o, busy_o, frame_done_o, err_o}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearLog();
        applyStimulus(1'b1, 9'd2, 1'b0, 16'h0);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0007);
        applyStimulus(1'b0, 9'd0, 1'b1, 16'h0008);
        checkOutput("t6_wr", {ram_wr_o, ram_addr_o, ram_data_o}, {1'b1, 10'h000, 32'h00080007});
        idleCycles(3);
        checkOutput("t6_nwrites", wr_addr_q.size(), 1);
        checkOutput("t6_done", {done_cnt[7:0], bank_o}, {8'd1, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
